// File: rtl/mul_seq_cell.sv
// mul_seq_cell: sequential signed/unsigned multiplier with valid/ready handshakes.
// The full 2*DATA_W product is built from N*N SLICE_W x SLICE_W partial products,
// one per cycle through a single multiplier. The operation works on operand
// magnitudes, and the sign of the product is applied once at the end.
module mul_seq_cell #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_a_signed,
    input  logic              in_b_signed,
    input  logic              in_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int NN    = N * N;
    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SIGN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_W-1:0]     r_mag_a;
    logic [DATA_W-1:0]     r_mag_b;
    logic                  r_neg;
    logic                  r_hi;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_result;

    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic                  w_last;
    logic [31:0]           w_i;
    logic [31:0]           w_j;
    logic [SLICE_W-1:0]    w_sl_a;
    logic [SLICE_W-1:0]    w_sl_b;
    logic [2*SLICE_W-1:0]  w_pp;
    logic [ACC_W-1:0]      w_pp_sh;
    logic [ACC_W-1:0]      w_acc_fixed;

    // Magnitudes stay DATA_W bits wide so the most negative value negates exactly.
    assign w_mag_a = (in_a_signed && in_a[DATA_W-1]) ? -in_a : in_a;
    assign w_mag_b = (in_b_signed && in_b[DATA_W-1]) ? -in_b : in_b;

    assign w_last      = (r_cnt == CNT_W'(NN - 1));
    assign w_i         = 32'(r_cnt) / 32'(N);
    assign w_j         = 32'(r_cnt) % 32'(N);
    assign w_acc_fixed = r_neg ? -r_acc : r_acc;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

    // Select slice i of |A| and slice j of |B|, form the partial product and align it.
    always_comb begin
        w_sl_a = '0;
        w_sl_b = '0;
        for (int unsigned s = 0; s < N; s++) begin
            if (w_i == s) w_sl_a = r_mag_a[s*SLICE_W +: SLICE_W];
            if (w_j == s) w_sl_b = r_mag_b[s*SLICE_W +: SLICE_W];
        end
        w_pp    = (2*SLICE_W)'(w_sl_a) * (2*SLICE_W)'(w_sl_b);
        w_pp_sh = ACC_W'(w_pp) << ((w_i + w_j) * 32'(SLICE_W));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic: abort wins over en, en gates every other transition.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else if (en) begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_next = S_MUL;
                S_MUL:   if (w_last)   w_state_next = S_SIGN;
                S_SIGN:  w_state_next = S_DONE;
                S_DONE:  if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, accumulation, sign fix-up and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag_a      <= '0;
            r_mag_b      <= '0;
            r_neg        <= 1'b0;
            r_hi         <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else if (abort) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= (in_a_signed & in_a[DATA_W-1]) ^ (in_b_signed & in_b[DATA_W-1]);
                        r_hi    <= in_hi;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
                S_SIGN: begin
                    r_acc        <= w_acc_fixed;
                    r_out_result <= r_hi ? w_acc_fixed[ACC_W-1:DATA_W] : w_acc_fixed[DATA_W-1:0];
                    r_out_valid  <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_cell.sv
// tb_mul_seq_cell: directed vector table plus hand-written control-path sequences.
module tb_mul_seq_cell;

    localparam int DW = 32;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_a_signed;
    logic          in_b_signed;
    logic          in_hi;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;

    int checks   = 0;
    int failures = 0;

    mul_seq_cell #(.DATA_W(32), .SLICE_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_a_signed (in_a_signed),
        .in_b_signed (in_b_signed),
        .in_hi       (in_hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sa;
        logic          sb;
        logic          hi;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sa, input logic sb, input logic hi);
        @(negedge clk);
        in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sb; in_hi = hi;
        in_valid = 1'b1;
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid rises; optional en stall window.
    task automatic wait_valid(input int stall_at, input int stall_len,
                              output int cyc, output bit busy_rdy);
        cyc = 0;
        busy_rdy = 1'b0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            if (in_ready) busy_rdy = 1'b1;
            if (stall_len > 0 && cyc == stall_at) en = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len) en = 1'b1;
        end
        en = 1'b1;
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout: out_valid not seen within %0d cycles", cyc);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input vec_t v, input int stall_at, input int stall_len, input int exp_lat);
        int cyc;
        bit busy;
        accept(v.a, v.b, v.sa, v.sb, v.hi);
        wait_valid(stall_at, stall_len, cyc, busy);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_not_ready", {63'd0, busy}, 64'd0);
        check("result", {32'd0, out_result}, {32'd0, v.exp});
        handshake();
    endtask

    initial begin
        int  cyc;
        bit  busy;
        bit  seen;
        vec_t v;

        vecs[0]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'h0000000F};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
        vecs[3]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFA};
        vecs[4]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
        vecs[9]  = '{32'h0000FFFF, 32'h00010001, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[10] = '{32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b1, 1'b0, 32'h00000000};
        vecs[11] = '{32'h00000007, 32'hFFFFFFFA, 1'b1, 1'b1, 1'b0, 32'hFFFFFFD6};

        reset_n = 1'b0; en = 1'b1; abort = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0; in_hi = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",   {63'd0, in_ready},  64'd1);
        check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_op(vecs[i], 0, 0, 5);

        // en low for three cycles during MUL stretches latency to 8.
        v = vecs[0];
        run_op(v, 1, 3, 8);

        // Consumer back-pressure, then an en=0 cycle that must block the handshake.
        accept(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        wait_valid(0, 0, cyc, busy);
        check("bp_latency", 64'(cyc), 64'd5);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid",  {63'd0, out_valid}, 64'd1);
            check("bp_hold_result", {32'd0, out_result}, 64'h0F);
        end
        en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done_valid", {63'd0, out_valid}, 64'd1);
        en = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_done_drop", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while in SIGN clears outputs without waiting for a clock.
        accept(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_sign_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_sign_result", {32'd0, out_result}, 64'd0);
        check("rst_sign_ready",  {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        v = '{32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd42};
        run_op(v, 0, 0, 5);

        // Abort during MUL returns to IDLE and no result appears.
        accept(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_ready", {63'd0, in_ready},  64'd1);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);

        // Abort coinciding with a request in IDLE drops the request.
        @(negedge clk);
        in_a = 32'd2; in_b = 32'd2; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; abort = 1'b0;
        check("abort_req_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_req_no_valid", {63'd0, seen}, 64'd0);

        v = vecs[11];
        run_op(v, 0, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
